// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: decodes loads/stores from execute, runs one req/ack
// data-memory transaction at a time and produces write-back data one stage later.
module rv32i_mem_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic [31:0] iw_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rs2_data_in,
   input  logic        in_valid,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] iw_out,
   output logic [31:0] wb_data_out,
   output logic        out_valid,
   output logic        misalign_out,
   output logic        bus_err_out
);

   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t state, state_nxt;

   logic [6:0]  opc_p0;
   logic [2:0]  f3_p0;
   logic        ld_p0, st_p0, mem_p0, mis_p0, acc_p0;

   logic [31:0] pc_p1, iw_p1, wb_p1;
   logic        vld_p1, mis_p1, berr_p1;
   logic [31:0] addr_p1, wdata_p1;
   logic [3:0]  be_p1;
   logic [2:0]  f3_p1;
   logic [1:0]  off_p1;
   logic        we_p1;
   logic [31:0] tmo_cnt;
   logic        tmo_hit;

   function automatic logic [3:0] be_gen(input logic is_st, input logic [2:0] f3,
                                         input logic [1:0] off);
      logic [3:0] be;
      be = 4'b1111;
      if (is_st) begin
         case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

   function automatic logic [31:0] wdata_gen(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{rs2[7:0]}};
         2'b01:   w = {2{rs2[15:0]}};
         default: w = rs2;
      endcase
      return w;
   endfunction

   // Narrow loads: pick the lane, then sign- or zero-extend from it.
   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] f3,
                                                input logic [1:0] off);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  r = 32'(b);
         3'b001:  r = 32'(h);
         3'b100:  r = 32'($unsigned(b));
         3'b101:  r = 32'($unsigned(h));
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Stage p0: decode of the instruction presented by execute
   always_comb begin
      opc_p0 = iw_in[6:0];
      f3_p0  = iw_in[14:12];
      ld_p0  = 1'b0;
      st_p0  = 1'b0;
      if (opc_p0 == OP_LOAD) begin
         case (f3_p0)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_p0 = 1'b1;
            default:                                ld_p0 = 1'b0;
         endcase
      end
      if (opc_p0 == OP_STORE) begin
         case (f3_p0)
            3'b000, 3'b001, 3'b010: st_p0 = 1'b1;
            default:                st_p0 = 1'b0;
         endcase
      end
      mem_p0 = ld_p0 | st_p0;
      case (f3_p0[1:0])
         2'b01:   mis_p0 = mem_p0 & alu_in[0];
         2'b10:   mis_p0 = mem_p0 & (|alu_in[1:0]);
         default: mis_p0 = 1'b0;
      endcase
      acc_p0 = in_valid && (state == IDLE);
   end

   // An ack in the cycle the count is reached takes priority over the abort.
   assign tmo_hit = TMO_EN && (state == ACCESS) && !dmem_ack && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc_p0 && mem_p0 && !mis_p0) state_nxt = ACCESS;
         ACCESS:  if (dmem_ack || tmo_hit)         state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p1: registered request and write-back results
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_p1    <= '0;
         iw_p1    <= '0;
         wb_p1    <= '0;
         vld_p1   <= 1'b0;
         mis_p1   <= 1'b0;
         berr_p1  <= 1'b0;
         addr_p1  <= '0;
         wdata_p1 <= '0;
         be_p1    <= '0;
         f3_p1    <= '0;
         off_p1   <= '0;
         we_p1    <= 1'b0;
         tmo_cnt  <= '0;
      end else begin
         vld_p1  <= 1'b0;
         mis_p1  <= 1'b0;
         berr_p1 <= 1'b0;
         if (state == ACCESS && !dmem_ack && !tmo_hit) tmo_cnt <= tmo_cnt + 32'd1;
         else                                          tmo_cnt <= '0;
         if (acc_p0) begin
            pc_p1 <= pc_in;
            iw_p1 <= iw_in;
            if (!mem_p0) begin
               vld_p1 <= 1'b1;
               wb_p1  <= alu_in;
            end else if (mis_p0) begin
               vld_p1 <= 1'b1;
               mis_p1 <= 1'b1;
               wb_p1  <= '0;
            end else begin
               addr_p1  <= {alu_in[31:2], 2'b00};
               off_p1   <= alu_in[1:0];
               f3_p1    <= f3_p0;
               we_p1    <= st_p0;
               be_p1    <= be_gen(st_p0, f3_p0, alu_in[1:0]);
               wdata_p1 <= st_p0 ? wdata_gen(f3_p0, rs2_data_in) : '0;
            end
         end else if (state == ACCESS) begin
            if (dmem_ack) begin
               vld_p1 <= 1'b1;
               wb_p1  <= we_p1 ? '0 : load_extract(dmem_rdata, f3_p1, off_p1);
            end else if (tmo_hit) begin
               vld_p1  <= 1'b1;
               berr_p1 <= 1'b1;
               wb_p1   <= '0;
            end
         end
      end
   end

   always_comb begin
      stall_out    = (state == ACCESS);
      dmem_req     = (state == ACCESS);
      dmem_we      = (state == ACCESS) ? we_p1    : 1'b0;
      dmem_be      = (state == ACCESS) ? be_p1    : 4'b0000;
      dmem_addr    = (state == ACCESS) ? addr_p1  : 32'd0;
      dmem_wdata   = (state == ACCESS) ? wdata_p1 : 32'd0;
      pc_out       = pc_p1;
      iw_out       = iw_p1;
      wb_data_out  = wb_p1;
      out_valid    = vld_p1;
      misalign_out = mis_p1;
      bus_err_out  = berr_p1;
   end

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Bench for rv32i_mem_stage: directed plan steps followed by randomized transactions
// scored against a transaction-level reference model.
module tb_rv32i_mem_stage;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
   logic        in_valid;
   logic        stall_out, dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] pc_out, iw_out, wb_data_out;
   logic        out_valid, misalign_out, bus_err_out;

   int checks   = 0;
   int failures = 0;

   rv32i_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
      .rs2_data_in(rs2_data_in), .in_valid(in_valid), .stall_out(stall_out),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out), .out_valid(out_valid),
      .misalign_out(misalign_out), .bus_err_out(bus_err_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
      logic [31:0] w;
      w = $urandom;
      w[6:0]   = op;
      w[14:12] = f3;
      return w;
   endfunction

   // 0 = pass-through, 1 = misaligned, 2 = memory access
   function automatic int classify(input logic [31:0] iw, input logic [31:0] addr);
      int unsigned f3, size;
      bit is_ld, is_st;
      f3    = iw[14:12];
      is_ld = (iw[6:0] == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      is_st = (iw[6:0] == 7'h23) && (f3 <= 2);
      if (!is_ld && !is_st) return 0;
      size = 1 << (f3 % 4);
      return ((addr % size) != 0) ? 1 : 2;
   endfunction

   function automatic logic [31:0] load_ref(input logic [31:0] iw, input logic [31:0] addr,
                                            input logic [31:0] rd);
      int unsigned off;
      logic [31:0] sh, v;
      off = addr % 4;
      sh  = rd >> (8 * off);
      case (iw[14:12])
         3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
         3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
         3'd4: v = sh & 32'hFF;
         3'd5: v = sh & 32'hFFFF;
         default: v = rd;
      endcase
      return v;
   endfunction

   // Runs one instruction from an idle sample point to the next idle sample point.
   // ack_dly = request cycle index that carries the ack; >= TMO means no ack.
   task automatic txn(input string tag, input logic [31:0] pc, input logic [31:0] iw,
                      input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rd,
                      input int ack_dly);
      int          kind;
      bit          is_st, timed_out;
      logic [31:0] exp_be, exp_wd, exp_wb;
      kind      = classify(iw, alu);
      is_st     = (iw[6:0] == 7'h23);
      timed_out = 1'b0;
      exp_be    = 32'hF;
      exp_wd    = rs2;
      if (is_st && iw[13:12] == 2'd0) begin
         exp_be = 32'd1 << (alu % 4);
         exp_wd = (rs2 & 32'hFF) * 32'h0101_0101;
      end else if (is_st && iw[13:12] == 2'd1) begin
         exp_be = 32'd3 << (alu % 4);
         exp_wd = (rs2 & 32'hFFFF) * 32'h0001_0001;
      end
      chk({tag, "_idle_stall"}, 32'(stall_out), 32'd0);
      pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2; in_valid = 1'b1;
      @(posedge clk); #1;
      if (kind != 2) begin
         in_valid = 1'b0;
         exp_wb = (kind == 0) ? alu : 32'd0;
         chk({tag, "_req"}, 32'(dmem_req), 32'd0);
         chk({tag, "_stall"}, 32'(stall_out), 32'd0);
         chk({tag, "_mis"}, 32'(misalign_out), (kind == 1) ? 32'd1 : 32'd0);
      end else begin
         for (int k = 0; k < TMO; k++) begin
            chk({tag, "_req"}, 32'(dmem_req), 32'd1);
            chk({tag, "_stall"}, 32'(stall_out), 32'd1);
            chk({tag, "_vld_busy"}, 32'(out_valid), 32'd0);
            chk({tag, "_addr"}, dmem_addr, alu & 32'hFFFF_FFFC);
            chk({tag, "_we"}, 32'(dmem_we), 32'(is_st));
            chk({tag, "_be"}, 32'(dmem_be), exp_be);
            if (is_st) chk({tag, "_wdata"}, dmem_wdata, exp_wd);
            if (k == ack_dly) begin
               dmem_ack = 1'b1; dmem_rdata = rd;
               @(posedge clk); #1;
               dmem_ack = 1'b0; dmem_rdata = $urandom;
               break;
            end
            @(posedge clk); #1;
            if (k == TMO - 1) timed_out = 1'b1;
         end
         in_valid = 1'b0;
         exp_wb = (timed_out || is_st) ? 32'd0 : load_ref(iw, alu, rd);
         chk({tag, "_req_done"}, 32'(dmem_req), 32'd0);
         chk({tag, "_stall_done"}, 32'(stall_out), 32'd0);
         chk({tag, "_mis"}, 32'(misalign_out), 32'd0);
      end
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_berr"}, 32'(bus_err_out), 32'(timed_out));
      chk({tag, "_wb"}, wb_data_out, exp_wb);
      chk({tag, "_pc"}, pc_out, pc);
      chk({tag, "_iw"}, iw_out, iw);
      dmem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
      chk({tag, "_qual"}, 32'({misalign_out, bus_err_out}), 32'd0);
      chk({tag, "_stray_ack"}, 32'(dmem_req), 32'd0);
   endtask

   initial begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      reset = 1'b0; in_valid = 1'b0; pc_in = '0; iw_in = '0; alu_in = '0;
      rs2_data_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      #22;
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall_out), 32'd0);
      chk("rst_wb", wb_data_out, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_flags", 32'({misalign_out, bus_err_out}), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      txn("addi", 32'h0000_1000, mk_iw(7'h13, 3'd0), 32'h0000_0010, 32'd0, 32'd0, 0);
      txn("lb", 32'h0000_1004, mk_iw(7'h03, 3'd0), 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 3);
      txn("lbu", 32'h0000_1008, mk_iw(7'h03, 3'd4), 32'h0000_0103, 32'd0, 32'h80AA_BBCC, 3);
      txn("sh", 32'h0000_100C, mk_iw(7'h23, 3'd1), 32'h0000_0202, 32'h1234_ABCD, 32'd0, 0);
      txn("lw_mis", 32'h0000_1010, mk_iw(7'h03, 3'd2), 32'h0000_0101, 32'd0, 32'd0, 0);
      txn("sw_tmo", 32'h0000_1014, mk_iw(7'h23, 3'd2), 32'h0000_0300, 32'hDEAD_BEEF, 32'd0, 99);
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("late_ack_vld", 32'(out_valid), 32'd0);
      chk("late_ack_req", 32'(dmem_req), 32'd0);

      // Reset dropped in the middle of an outstanding LW.
      pc_in = 32'h0000_2000; iw_in = mk_iw(7'h03, 3'd2); alu_in = 32'h0000_0040; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("mid_req_before", 32'(dmem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_stall", 32'(stall_out), 32'd0);
      chk("mid_rst_vld", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_vld", 32'(out_valid), 32'd0);
      txn("addi_post", 32'h0000_2004, mk_iw(7'h13, 3'd0), 32'h0000_0777, 32'd0, 32'd0, 0);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         op  = (sel < 4) ? 7'h03 : (sel < 8) ? 7'h23 : (sel == 8) ? 7'h13 : 7'($urandom);
         f3  = 3'($urandom);
         a   = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         txn("rnd", $urandom, mk_iw(op, f3), a, $urandom, $urandom, $urandom_range(0, 5));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
